study_ctrl: RTL and testbench
=============================

# study_ctrl

Parametrised study-mode controller for the keyboard-synth design. It sits between the key/hit decoder, the song ROM, the sound engine and the note LEDs. It guides the player through a stored song one note at a time and advances only on a correct hit, counting misses. It also records played notes into an internal buffer of configurable depth and replays them through the sound engine.

## Interface
- OCT_W, 3, octave field width
- NOTE_W, 3, note field width; 0 = rest, 1..7 = do..si
- LEN_W, 2, length code width
- IDX_W, 6, song note index width
- REC_DEPTH, 32, record buffer entries (power of two, ≥2)
- MISS_W, 8, miss counter width (saturating)

Ports:
- clk  in  1  system clock (the design's only clock)
- rst_n  in  1  synchronous, active-low reset
- en  in  1  mode enable; low forces IDLE
- mode  in  2  0 guided, 1 record, 2 replay, 3 reserved (treated as guided)
- clr_rec  in  1  one-cycle pulse; empties the record buffer
- hit_valid  in  1  one-cycle pulse from the hit decoder
- hit_octave / hit_note / hit_length  in  OCT_W / NOTE_W / LEN_W  hit fields, valid with hit_valid
- song_idx  out  IDX_W  current song note index to the song ROM
- song_last  in  IDX_W  index of the final note of the selected song
- goal_octave / goal_note / goal_length  in  OCT_W / NOTE_W / LEN_W  ROM data for song_idx (combinational)
- snd_start  out  1  one-cycle request to the sound engine
- snd_octave / snd_note / snd_length  out  OCT_W / NOTE_W / LEN_W  held stable from snd_start until snd_done
- snd_done  in  1  one-cycle pulse; the sound engine has finished
- goal_led  out  7  one-hot of goal_note−1 in guided mode, else 0
- miss_cnt  out  MISS_W  wrong hits in the current run
- rec_count  out  $clog2(REC_DEPTH)+1  valid buffer entries
- rec_full  out  1  rec_count == REC_DEPTH
- done  out  1  sticky; the run has finished

## Operation
- States: IDLE, WAIT_HIT, SOUND, RP_FETCH, RP_PLAY, DONE.
- IDLE: song_idx, miss_cnt and done are cleared. The mode is sampled here only. When en=1, modes 0, 1 and 3 go to WAIT_HIT, and mode 2 goes to RP_FETCH.
- WAIT_HIT in guided mode:
  - If goal_note==0 (a rest), issue snd_start with the goal fields with no hit, and latch match=1.
  - Otherwise, on hit_valid, issue snd_start with the hit fields and latch match = (octave equal AND note equal). Length is ignored for match.
  - Both cases go to SOUND.
- WAIT_HIT in record mode: on hit_valid, sound the hit. If not full, write {octave,note,length} at rec_count and increment rec_count. When full, the hit is still sounded but not written.
- SOUND: hit_valid is ignored. On snd_done, in guided mode:
  - If match and song_idx==song_last, set done and go to DONE.
  - If match otherwise, increment song_idx and go to WAIT_HIT.
  - If mismatch, increment miss_cnt (saturating at all-ones) and go to WAIT_HIT with song_idx unchanged.
  - In record mode, go to WAIT_HIT.
- RP_FETCH: rd_ptr=0 on entry. If rd_ptr==rec_count, set done and go to DONE. Otherwise read the entry and go to RP_PLAY.
- RP_PLAY: snd_start with the entry. On snd_done, increment rd_ptr and go to RP_FETCH.
- DONE: hold all outputs. Leave only via en=0.
- en=0 in any state: go to IDLE the next cycle. The buffer contents and rec_count are retained.
- clr_rec: rec_count←0 and rec_full←0. It is ignored while in RP_FETCH or RP_PLAY.
- Simultaneous clr_rec and a record write: clr_rec wins and nothing is written.

## Timing
- Reset values: state IDLE. song_idx, miss_cnt, rec_count, snd_start, snd_* fields, goal_led and done are all 0. rec_full is 0.
- hit_valid in cycle N gives snd_start=1 in cycle N+1, with snd_* valid the same cycle. The buffer write also occurs at N+1.
- snd_done in cycle M updates song_idx and miss_cnt in cycle M+1. The state is WAIT_HIT in M+1.
- A rest goal fires snd_start in the cycle after entering WAIT_HIT.
- Replay spacing: 2 cycles from snd_done to the next snd_start (FETCH, then PLAY).
- goal_led is registered from goal_note and lags song_idx by one cycle.
- snd_done outside SOUND or RP_PLAY is ignored.
- A reset mid-sound drops the request. The sound engine must tolerate snd_start never completing.

## Structure
- Shared package `study_pkg`: state enum, mode encodings (MODE_GUIDED/RECORD/REPLAY), rest note code, note field widths, and the packed note record type {octave,note,length}.
- Sub-module `rec_buffer`: REC_DEPTH×(OCT_W+NOTE_W+LEN_W) synchronous RAM with write port and registered read (1-cycle latency, absorbed by RP_FETCH).
- Controller FSM, counters and LED decode stay in `study_ctrl`.

## Test plan
- Guided, song_last=2, goals (4,1),(4,3),(5,5). Correct hits produce song_idx 0→1→2, then done=1 after the third snd_done, with miss_cnt=0.
- Guided, goal (4,1), hit (4,2), then hit (4,1). Gives miss_cnt=1 and song_idx stays 0, then song_idx=1. With MISS_W=2, five misses saturate miss_cnt at 3.
- Guided, goal note 0 (rest), no hits. snd_start fires with the goal fields and the index advances after snd_done.
- Record, REC_DEPTH=4, six hits. rec_count=4 and rec_full=1. All six are sounded. Buffer holds the first four.
- Replay after the above. Four snd_starts replay the recorded fields in order, then done=1. Replay with an empty buffer gives done=1 in 2 cycles with no snd_start.
- Drop en mid-SOUND in guided mode. IDLE the next cycle with song_idx/miss_cnt/done=0 and rec_count unchanged. A later snd_done is ignored. rst_n low for 1 cycle also clears rec_count.

Source files
------------

// File: rtl/study_pkg.sv
// Shared types and encodings for the study-mode controller of the keyboard synth.
package study_pkg;

    // Default field widths of one note record {octave, note, length}
    localparam int DEF_OCT_W  = 3;
    localparam int DEF_NOTE_W = 3;
    localparam int DEF_LEN_W  = 2;

    // Mode encodings sampled in IDLE; the reserved code behaves like guided
    localparam logic [1:0] MODE_GUIDED   = 2'd0;
    localparam logic [1:0] MODE_RECORD   = 2'd1;
    localparam logic [1:0] MODE_REPLAY   = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    // Note code that stands for a rest (no key expected)
    localparam int REST_NOTE = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HIT,
        S_SOUND,
        S_RP_FETCH,
        S_RP_PLAY,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_OCT_W-1:0]  octave;
        logic [DEF_NOTE_W-1:0] note;
        logic [DEF_LEN_W-1:0]  length;
    } note_rec_t;

    function automatic logic is_guided(input logic [1:0] m);
        return (m == MODE_GUIDED) || (m == MODE_RESERVED);
    endfunction

endpackage

// File: rtl/study_rec_buffer.sv
// Record buffer: single-clock RAM with one write port and a registered read port.
module rec_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write on demand and read every cycle; read data appears one cycle after the address
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/study_ctrl.sv
// Study-mode controller: guided play through a song, recording of hits and replay.
module study_ctrl
    import study_pkg::*;
#(
    parameter int OCT_W     = DEF_OCT_W,
    parameter int NOTE_W    = DEF_NOTE_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int IDX_W     = 6,
    parameter int REC_DEPTH = 32,
    parameter int MISS_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       clr_rec,
    input  logic                       hit_valid,
    input  logic [OCT_W-1:0]           hit_octave,
    input  logic [NOTE_W-1:0]          hit_note,
    input  logic [LEN_W-1:0]           hit_length,
    output logic [IDX_W-1:0]           song_idx,
    input  logic [IDX_W-1:0]           song_last,
    input  logic [OCT_W-1:0]           goal_octave,
    input  logic [NOTE_W-1:0]          goal_note,
    input  logic [LEN_W-1:0]           goal_length,
    output logic                       snd_start,
    output logic [OCT_W-1:0]           snd_octave,
    output logic [NOTE_W-1:0]          snd_note,
    output logic [LEN_W-1:0]           snd_length,
    input  logic                       snd_done,
    output logic [6:0]                 goal_led,
    output logic [MISS_W-1:0]          miss_cnt,
    output logic [$clog2(REC_DEPTH):0] rec_count,
    output logic                       rec_full,
    output logic                       done
);

    localparam int AW = $clog2(REC_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = OCT_W + NOTE_W + LEN_W;

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [IDX_W-1:0]    songIdx_q;
    logic [MISS_W-1:0]   missCnt_q;
    logic                done_q;
    logic                match_q;
    logic                sndStart_q;
    logic [OCT_W-1:0]    sndOct_q;
    logic [NOTE_W-1:0]   sndNote_q;
    logic [LEN_W-1:0]    sndLen_q;
    logic [6:0]          goalLed_q, goalLed_d;
    logic [CW-1:0]       recCount_q, recCount_d;
    logic [CW-1:0]       rdPtr_q, rdPtr_d;
    logic                recFull;
    logic                clrOk;
    logic                recWe;
    logic [RW-1:0]       rdData;

    // Buffer bookkeeping, replay read pointer look-ahead and LED decode
    always_comb begin
        recFull    = (recCount_q == CW'(REC_DEPTH));
        clrOk      = clr_rec && (state_q != S_RP_FETCH) && (state_q != S_RP_PLAY);
        recWe      = en && (state_q == S_WAIT_HIT) && (mode_q == MODE_RECORD) &&
                     hit_valid && !recFull && !clrOk;
        recCount_d = recCount_q;
        if (clrOk) begin
            recCount_d = '0;
        end else if (recWe) begin
            recCount_d = recCount_q + CW'(1);
        end
        rdPtr_d = rdPtr_q;
        if (state_q == S_IDLE) begin
            rdPtr_d = '0;
        end else if ((state_q == S_RP_PLAY) && snd_done) begin
            rdPtr_d = rdPtr_q + CW'(1);
        end
        goalLed_d = '0;
        if (en) begin
            if (state_q == S_DONE) begin
                goalLed_d = goalLed_q;
            end else if (is_guided(mode_q) &&
                         ((state_q == S_WAIT_HIT) || (state_q == S_SOUND))) begin
                for (int i = 0; i < 7; i++) begin
                    goalLed_d[i] = (goal_note == NOTE_W'(i + 1));
                end
            end
        end
    end

    // Record count survives en=0 and is cleared only by reset or clr_rec
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            recCount_q <= '0;
        end else begin
            recCount_q <= recCount_d;
        end
    end

    // Main controller FSM with registered sound request, progress and LED outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_GUIDED;
            songIdx_q  <= '0;
            missCnt_q  <= '0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            sndStart_q <= 1'b0;
            sndOct_q   <= '0;
            sndNote_q  <= '0;
            sndLen_q   <= '0;
            goalLed_q  <= '0;
            rdPtr_q    <= '0;
        end else begin
            sndStart_q <= 1'b0;
            goalLed_q  <= goalLed_d;
            rdPtr_q    <= rdPtr_d;
            if (state_q == S_IDLE) begin
                mode_q <= mode;
            end
            if (!en) begin
                state_q   <= S_IDLE;
                songIdx_q <= '0;
                missCnt_q <= '0;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        songIdx_q <= '0;
                        missCnt_q <= '0;
                        done_q    <= 1'b0;
                        state_q   <= (mode == MODE_REPLAY) ? S_RP_FETCH : S_WAIT_HIT;
                    end
                    S_WAIT_HIT: begin
                        if (is_guided(mode_q) && (goal_note == NOTE_W'(REST_NOTE))) begin
                            sndStart_q <= 1'b1;
                            sndOct_q   <= goal_octave;
                            sndNote_q  <= goal_note;
                            sndLen_q   <= goal_length;
                            match_q    <= 1'b1;
                            state_q    <= S_SOUND;
                        end else if (hit_valid) begin
                            sndStart_q <= 1'b1;
                            sndOct_q   <= hit_octave;
                            sndNote_q  <= hit_note;
                            sndLen_q   <= hit_length;
                            match_q    <= (hit_octave == goal_octave) && (hit_note == goal_note);
                            state_q    <= S_SOUND;
                        end
                    end
                    S_SOUND: begin
                        if (snd_done) begin
                            state_q <= S_WAIT_HIT;
                            if (is_guided(mode_q)) begin
                                if (match_q && (songIdx_q == song_last)) begin
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end else if (match_q) begin
                                    songIdx_q <= songIdx_q + IDX_W'(1);
                                end else if (missCnt_q != {MISS_W{1'b1}}) begin
                                    missCnt_q <= missCnt_q + MISS_W'(1);
                                end
                            end
                        end
                    end
                    S_RP_FETCH: begin
                        if (rdPtr_q == recCount_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            sndStart_q <= 1'b1;
                            sndOct_q   <= rdData[RW-1 -: OCT_W];
                            sndNote_q  <= rdData[LEN_W +: NOTE_W];
                            sndLen_q   <= rdData[LEN_W-1:0];
                            state_q    <= S_RP_PLAY;
                        end
                    end
                    S_RP_PLAY: begin
                        if (snd_done) begin
                            state_q <= S_RP_FETCH;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_DONE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    rec_buffer #(
        .DEPTH (REC_DEPTH),
        .WIDTH (RW),
        .AW    (AW)
    ) u_rec_buffer (
        .clk_i   (clk),
        .we_i    (recWe),
        .waddr_i (recCount_q[AW-1:0]),
        .wdata_i ({hit_octave, hit_note, hit_length}),
        .raddr_i (rdPtr_d[AW-1:0]),
        .rdata_o (rdData)
    );

    assign song_idx   = songIdx_q;
    assign snd_start  = sndStart_q;
    assign snd_octave = sndOct_q;
    assign snd_note   = sndNote_q;
    assign snd_length = sndLen_q;
    assign goal_led   = goalLed_q;
    assign miss_cnt   = missCnt_q;
    assign rec_count  = recCount_q;
    assign rec_full   = recFull;
    assign done       = done_q;

endmodule

// File: tb/tb_study_ctrl.sv
// Directed bench for study_ctrl: guided play, misses, rests, record, replay, clear and en drop.
module tb_study_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       clr_rec;
    logic       hit_valid;
    logic [2:0] hit_octave;
    logic [2:0] hit_note;
    logic [1:0] hit_length;
    logic [5:0] song_idx;
    logic [5:0] song_last;
    logic [2:0] goal_octave;
    logic [2:0] goal_note;
    logic [1:0] goal_length;
    logic       snd_start;
    logic [2:0] snd_octave;
    logic [2:0] snd_note;
    logic [1:0] snd_length;
    logic       snd_done;
    logic [6:0] goal_led;
    logic [1:0] miss_cnt;
    logic [2:0] rec_count;
    logic       rec_full;
    logic       done;

    logic [2:0] romOct  [64];
    logic [2:0] romNote [64];
    logic [1:0] romLen  [64];

    int total = 0;
    int bad   = 0;

    // Free-running clock; inputs change and outputs are sampled on the falling edge
    always #5 clk = ~clk;

    assign goal_octave = romOct[song_idx];
    assign goal_note   = romNote[song_idx];
    assign goal_length = romLen[song_idx];

    study_ctrl #(
        .OCT_W(3), .NOTE_W(3), .LEN_W(2), .IDX_W(6), .REC_DEPTH(4), .MISS_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .clr_rec(clr_rec),
        .hit_valid(hit_valid), .hit_octave(hit_octave), .hit_note(hit_note),
        .hit_length(hit_length), .song_idx(song_idx), .song_last(song_last),
        .goal_octave(goal_octave), .goal_note(goal_note), .goal_length(goal_length),
        .snd_start(snd_start), .snd_octave(snd_octave), .snd_note(snd_note),
        .snd_length(snd_length), .snd_done(snd_done), .goal_led(goal_led),
        .miss_cnt(miss_cnt), .rec_count(rec_count), .rec_full(rec_full), .done(done)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_hit(input logic [2:0] o, input logic [2:0] n, input logic [1:0] l);
        hit_octave = o;
        hit_note   = n;
        hit_length = l;
        hit_valid  = 1'b1;
        @(negedge clk);
        hit_valid  = 1'b0;
    endtask

    task automatic pulse_done();
        snd_done = 1'b1;
        @(negedge clk);
        snd_done = 1'b0;
    endtask

    task automatic set_rom(input int idx, input logic [2:0] o, input logic [2:0] n, input logic [1:0] l);
        romOct[idx]  = o;
        romNote[idx] = n;
        romLen[idx]  = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        total++; if (song_idx !== 6'd0) begin bad++; $display("[TB] FAIL reset_song_idx got=%0d exp=0", song_idx); end
        total++; if (miss_cnt !== 2'd0) begin bad++; $display("[TB] FAIL reset_miss_cnt got=%0d exp=0", miss_cnt); end
        total++; if (rec_count !== 3'd0) begin bad++; $display("[TB] FAIL reset_rec_count got=%0d exp=0", rec_count); end
        total++; if (rec_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_rec_full got=%0b exp=0", rec_full); end
        total++; if (snd_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_snd_start got=%0b exp=0", snd_start); end
        total++; if ({snd_octave, snd_note, snd_length} !== 8'h00) begin bad++; $display("[TB] FAIL reset_snd_fields got=%0h exp=0", {snd_octave, snd_note, snd_length}); end
        total++; if (goal_led !== 7'd0) begin bad++; $display("[TB] FAIL reset_goal_led got=%0b exp=0", goal_led); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
    endtask

    task automatic test_guided_song();
        set_rom(0, 3'd4, 3'd1, 2'd1);
        set_rom(1, 3'd4, 3'd3, 2'd2);
        set_rom(2, 3'd5, 3'd5, 2'd3);
        song_last = 6'd2;
        mode = 2'd0;
        en = 1'b1;
        tick();
        tick();
        total++; if (goal_led !== 7'b0000001) begin bad++; $display("[TB] FAIL guided_led0 got=%0b exp=0000001", goal_led); end
        pulse_hit(3'd4, 3'd1, 2'd2);
        total++; if (snd_start !== 1'b1) begin bad++; $display("[TB] FAIL guided_start0 got=%0b exp=1", snd_start); end
        total++; if ({snd_octave, snd_note, snd_length} !== {3'd4, 3'd1, 2'd2}) begin bad++; $display("[TB] FAIL guided_fields0 got=%0h exp=%0h", {snd_octave, snd_note, snd_length}, {3'd4, 3'd1, 2'd2}); end
        tick();
        total++; if (snd_start !== 1'b0) begin bad++; $display("[TB] FAIL guided_start_pulse got=%0b exp=0", snd_start); end
        pulse_done();
        total++; if (song_idx !== 6'd1) begin bad++; $display("[TB] FAIL guided_idx1 got=%0d exp=1", song_idx); end
        tick();
        total++; if (goal_led !== 7'b0000100) begin bad++; $display("[TB] FAIL guided_led1 got=%0b exp=0000100", goal_led); end
        pulse_hit(3'd4, 3'd3, 2'd0);
        pulse_done();
        total++; if (song_idx !== 6'd2) begin bad++; $display("[TB] FAIL guided_idx2 got=%0d exp=2", song_idx); end
        pulse_hit(3'd5, 3'd5, 2'd1);
        total++; if ({snd_octave, snd_note, snd_length} !== {3'd5, 3'd5, 2'd1}) begin bad++; $display("[TB] FAIL guided_fields2 got=%0h exp=%0h", {snd_octave, snd_note, snd_length}, {3'd5, 3'd5, 2'd1}); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL guided_done_early got=%0b exp=0", done); end
        pulse_done();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL guided_done got=%0b exp=1", done); end
        total++; if (miss_cnt !== 2'd0) begin bad++; $display("[TB] FAIL guided_miss got=%0d exp=0", miss_cnt); end
        total++; if (song_idx !== 6'd2) begin bad++; $display("[TB] FAIL guided_idx_final got=%0d exp=2", song_idx); end
        pulse_hit(3'd5, 3'd5, 2'd1);
        total++; if (snd_start !== 1'b0) begin bad++; $display("[TB] FAIL done_ignores_hit got=%0b exp=0", snd_start); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL done_sticky got=%0b exp=1", done); end
        en = 1'b0;
        tick();
        total++; if ({done, song_idx, goal_led} !== 14'd0) begin bad++; $display("[TB] FAIL guided_idle_clear got=%0h exp=0", {done, song_idx, goal_led}); end
    endtask

    task automatic test_miss();
        set_rom(0, 3'd4, 3'd1, 2'd0);
        set_rom(1, 3'd4, 3'd2, 2'd0);
        song_last = 6'd1;
        mode = 2'd0;
        en = 1'b1;
        tick();
        pulse_hit(3'd4, 3'd2, 2'd0);
        total++; if (snd_note !== 3'd2) begin bad++; $display("[TB] FAIL miss_hit_note got=%0d exp=2", snd_note); end
        pulse_hit(3'd4, 3'd1, 2'd0);
        total++; if (snd_start !== 1'b0) begin bad++; $display("[TB] FAIL sound_ignores_hit got=%0b exp=0", snd_start); end
        total++; if (snd_note !== 3'd2) begin bad++; $display("[TB] FAIL sound_holds_note got=%0d exp=2", snd_note); end
        pulse_done();
        total++; if (miss_cnt !== 2'd1) begin bad++; $display("[TB] FAIL miss_cnt1 got=%0d exp=1", miss_cnt); end
        total++; if (song_idx !== 6'd0) begin bad++; $display("[TB] FAIL miss_idx_held got=%0d exp=0", song_idx); end
        pulse_hit(3'd4, 3'd1, 2'd0);
        pulse_done();
        total++; if (song_idx !== 6'd1) begin bad++; $display("[TB] FAIL miss_then_hit_idx got=%0d exp=1", song_idx); end
        for (int i = 0; i < 5; i++) begin
            pulse_hit(3'd3, 3'd2, 2'd0);
            pulse_done();
        end
        total++; if (miss_cnt !== 2'd3) begin bad++; $display("[TB] FAIL miss_saturate got=%0d exp=3", miss_cnt); end
        total++; if (song_idx !== 6'd1) begin bad++; $display("[TB] FAIL miss_octave_idx got=%0d exp=1", song_idx); end
        pulse_hit(3'd4, 3'd2, 2'd3);
        pulse_done();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL length_ignored_done got=%0b exp=1", done); end
        total++; if (miss_cnt !== 2'd3) begin bad++; $display("[TB] FAIL miss_final got=%0d exp=3", miss_cnt); end
        en = 1'b0;
        tick();
    endtask

    task automatic test_rest();
        set_rom(0, 3'd3, 3'd0, 2'd2);
        set_rom(1, 3'd4, 3'd1, 2'd0);
        song_last = 6'd1;
        mode = 2'd3;
        en = 1'b1;
        tick();
        total++; if (snd_start !== 1'b0) begin bad++; $display("[TB] FAIL rest_start_early got=%0b exp=0", snd_start); end
        tick();
        total++; if (snd_start !== 1'b1) begin bad++; $display("[TB] FAIL rest_start got=%0b exp=1", snd_start); end
        total++; if ({snd_octave, snd_note, snd_length} !== {3'd3, 3'd0, 2'd2}) begin bad++; $display("[TB] FAIL rest_fields got=%0h exp=%0h", {snd_octave, snd_note, snd_length}, {3'd3, 3'd0, 2'd2}); end
        total++; if (goal_led !== 7'd0) begin bad++; $display("[TB] FAIL rest_led got=%0b exp=0", goal_led); end
        pulse_done();
        total++; if (song_idx !== 6'd1) begin bad++; $display("[TB] FAIL rest_advance got=%0d exp=1", song_idx); end
        tick();
        total++; if (snd_start !== 1'b0) begin bad++; $display("[TB] FAIL rest_next_waits got=%0b exp=0", snd_start); end
        en = 1'b0;
        tick();
    endtask

    task automatic test_record();
        mode = 2'd1;
        en = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            pulse_hit(3'(i + 1), 3'(i + 1), 2'(i % 4));
            total++; if (snd_start !== 1'b1 || snd_note !== 3'(i + 1)) begin bad++; $display("[TB] FAIL record_sound%0d got=%0b/%0d exp=1/%0d", i, snd_start, snd_note, i + 1); end
            total++; if (rec_count !== 3'((i < 4) ? i + 1 : 4)) begin bad++; $display("[TB] FAIL record_count%0d got=%0d exp=%0d", i, rec_count, (i < 4) ? i + 1 : 4); end
            pulse_done();
        end
        total++; if (rec_full !== 1'b1) begin bad++; $display("[TB] FAIL record_full got=%0b exp=1", rec_full); end
        en = 1'b0;
        tick();
        total++; if (rec_count !== 3'd4) begin bad++; $display("[TB] FAIL record_kept got=%0d exp=4", rec_count); end
    endtask

    task automatic test_replay();
        mode = 2'd2;
        en = 1'b1;
        tick();
        total++; if (snd_start !== 1'b0) begin bad++; $display("[TB] FAIL replay_fetch_quiet got=%0b exp=0", snd_start); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (snd_start !== 1'b1) begin bad++; $display("[TB] FAIL replay_start%0d got=%0b exp=1", i, snd_start); end
            total++; if ({snd_octave, snd_note, snd_length} !== {3'(i + 1), 3'(i + 1), 2'(i % 4)}) begin bad++; $display("[TB] FAIL replay_fields%0d got=%0h exp=%0h", i, {snd_octave, snd_note, snd_length}, {3'(i + 1), 3'(i + 1), 2'(i % 4)}); end
            clr_rec = (i == 1);
            pulse_done();
            clr_rec = 1'b0;
            total++; if (snd_start !== 1'b0) begin bad++; $display("[TB] FAIL replay_gap%0d got=%0b exp=0", i, snd_start); end
        end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL replay_done got=%0b exp=1", done); end
        total++; if (snd_start !== 1'b0) begin bad++; $display("[TB] FAIL replay_no_extra got=%0b exp=0", snd_start); end
        total++; if (rec_count !== 3'd4) begin bad++; $display("[TB] FAIL replay_clr_ignored got=%0d exp=4", rec_count); end
        en = 1'b0;
        tick();
    endtask

    task automatic test_empty_replay();
        clr_rec = 1'b1;
        tick();
        clr_rec = 1'b0;
        total++; if (rec_count !== 3'd0 || rec_full !== 1'b0) begin bad++; $display("[TB] FAIL clr_rec got=%0d/%0b exp=0/0", rec_count, rec_full); end
        mode = 2'd2;
        en = 1'b1;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL empty_done_early got=%0b exp=0", done); end
        tick();
        total++; if (done !== 1'b1 || snd_start !== 1'b0) begin bad++; $display("[TB] FAIL empty_done got=%0b/%0b exp=1/0", done, snd_start); end
        en = 1'b0;
        tick();
    endtask

    task automatic test_clr_vs_write();
        mode = 2'd1;
        en = 1'b1;
        tick();
        clr_rec = 1'b1;
        pulse_hit(3'd7, 3'd7, 2'd3);
        clr_rec = 1'b0;
        total++; if (snd_start !== 1'b1 || rec_count !== 3'd0) begin bad++; $display("[TB] FAIL clr_wins got=%0b/%0d exp=1/0", snd_start, rec_count); end
        pulse_done();
        pulse_hit(3'd2, 3'd5, 2'd1);
        total++; if (rec_count !== 3'd1) begin bad++; $display("[TB] FAIL write_after_clr got=%0d exp=1", rec_count); end
        pulse_done();
        en = 1'b0;
        tick();
    endtask

    task automatic test_en_drop();
        set_rom(0, 3'd4, 3'd1, 2'd0);
        set_rom(1, 3'd4, 3'd3, 2'd0);
        set_rom(2, 3'd5, 3'd5, 2'd0);
        song_last = 6'd2;
        mode = 2'd0;
        en = 1'b1;
        tick();
        pulse_hit(3'd4, 3'd2, 2'd0);
        pulse_done();
        pulse_hit(3'd4, 3'd1, 2'd0);
        pulse_done();
        total++; if (song_idx !== 6'd1 || miss_cnt !== 2'd1) begin bad++; $display("[TB] FAIL drop_setup got=%0d/%0d exp=1/1", song_idx, miss_cnt); end
        pulse_hit(3'd4, 3'd3, 2'd0);
        en = 1'b0;
        tick();
        total++; if (song_idx !== 6'd0 || miss_cnt !== 2'd0 || done !== 1'b0) begin bad++; $display("[TB] FAIL drop_idle got=%0d/%0d/%0b exp=0/0/0", song_idx, miss_cnt, done); end
        total++; if (rec_count !== 3'd1) begin bad++; $display("[TB] FAIL drop_rec_kept got=%0d exp=1", rec_count); end
        en = 1'b1;
        tick();
        pulse_done();
        total++; if (song_idx !== 6'd0 || miss_cnt !== 2'd0 || snd_start !== 1'b0) begin bad++; $display("[TB] FAIL late_done_ignored got=%0d/%0d/%0b exp=0/0/0", song_idx, miss_cnt, snd_start); end
        en = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (rec_count !== 3'd0 || rec_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_clears_rec got=%0d/%0b exp=0/0", rec_count, rec_full); end
    endtask

    // Runs every scenario in order and prints the single summary line
    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; clr_rec = 1'b0; hit_valid = 1'b0;
        hit_octave = '0; hit_note = '0; hit_length = '0; snd_done = 1'b0; song_last = '0;
        for (int i = 0; i < 64; i++) set_rom(i, 3'd0, 3'd1, 2'd0);
        test_reset();
        test_guided_song();
        test_miss();
        test_rest();
        test_record();
        test_replay();
        test_empty_replay();
        test_clr_vs_write();
        test_en_drop();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
